egress_arbiter: RTL and testbench
=================================

EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
REQ-001 The block SHALL have the parameter NUM_PORTS, default 4, giving the number of packet-generator requesters.
REQ-002 The block SHALL have the parameter SOP_TIMEOUT, default 64, giving the cycles to wait for start-of-packet; it is used only with WATCHDOG_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NUM_PORTS bits: requester i has at least one packet queued.
REQ-006 The block SHALL have port in_ready, input, NUM_PORTS bits: requester i presents the first word of a packet this cycle.
REQ-007 The block SHALL have port in_data, input, NUM_PORTS*32 bits: word of requester i in bits [32i+31:32i].
REQ-008 The block SHALL have port out_stall, input, 1 bit: downstream backpressure.
REQ-009 The block SHALL have port send_en, output, NUM_PORTS bits: one-hot advance enable to the granted requester.
REQ-010 The block SHALL have ports out_data (32 bits), out_valid, out_sop, out_eop (1 bit each) and out_port ($clog2(NUM_PORTS) bits), all outputs: the registered forwarded stream.
REQ-011 The block SHALL have port err_timeout, output, 1 bit: one-cycle pulse on watchdog abort.

Function
REQ-012 The state machine SHALL have the states IDLE, WAIT_SOP and STREAM.
REQ-013 IDLE: when req is nonzero, the block SHALL select the winner round-robin, searching from last_grant+1 with wrap-around, latch it as grant, and move to WAIT_SOP on the next edge.
REQ-014 send_en[grant] SHALL be high in WAIT_SOP and STREAM whenever out_stall is 0 (combinational on out_stall); all other send_en bits SHALL be 0.
REQ-015 WAIT_SOP: on in_ready[grant]=1 with send_en high, the block SHALL forward the word with sop and latch remaining = max(word[31:18], 8) - 1, where word[31:16] is the length in bytes and word count = bytes/4 with a minimum of 8.
REQ-016 STREAM: each cycle with send_en high, the block SHALL forward one word and decrement remaining; the word forwarded when remaining==1 SHALL carry eop, after which the state SHALL return to IDLE and last_grant SHALL equal grant.
REQ-017 A packet whose remaining value is 0 after the SOP word SHALL be impossible (minimum 8 words), so sop and eop SHALL never coincide.
REQ-018 Outputs SHALL be registered with 1-cycle latency: out_valid, out_data, out_sop, out_eop and out_port reflect the input cycle in which send_en was high.
REQ-019 When send_en is low, out_valid SHALL be 0 and out_data SHALL hold its previous value.
REQ-020 Deassertion of req[grant] during STREAM SHALL be ignored until eop; deassertion in WAIT_SOP SHALL return the FSM to IDLE with last_grant=grant and no output.
REQ-021 Requests from non-granted ports SHALL never preempt an in-flight packet.
REQ-022 A new grant SHALL be issued no earlier than the cycle after eop (IDLE occupies one cycle).

Reset
REQ-023 While reset is asserted, state SHALL be IDLE, last_grant SHALL be NUM_PORTS-1 (port 0 wins first), remaining SHALL be 0, send_en SHALL be 0, all out_* SHALL be 0, and err_timeout SHALL be 0.
REQ-024 Reset mid-packet SHALL drop the packet without emitting eop.

Configuration
REQ-025 With WATCHDOG_EN defined, a cycle counter SHALL run in WAIT_SOP; on reaching SOP_TIMEOUT without in_ready[grant], the block SHALL pulse err_timeout for one cycle, go to IDLE, and advance last_grant to grant.
REQ-026 Without WATCHDOG_EN, err_timeout SHALL be tied 0, no counter SHALL be instantiated, and WAIT_SOP SHALL wait indefinitely.

Structure
REQ-027 The shared package switch_pkg SHALL hold NUM_PORTS, WORD_W=32, MIN_PKT_WORDS=8 and the arbiter state enum typedef.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter, taking req and last_grant and returning a one-hot grant and a valid flag.

Verification
REQ-029 Test: after reset, req=4'b1111 with all packets 64 bytes -> grants in order 0,1,2,3,0, each giving 16 out_valid words, sop on word 1 and eop on word 16.
REQ-030 Test: only port 2 requests, length 0x0010 -> packet forced to 8 words, eop on the 8th, out_port=2.
REQ-031 Test: out_stall high for 3 cycles mid-packet -> send_en low for those 3 cycles, 3 gaps in out_valid, word order intact, 16 words total.
REQ-032 Test: port 1 streaming 2048 bytes while port 0 raises req -> no preemption, 512 words from port 1, then port 2/3/0 per round-robin.
REQ-033 Test: WATCHDOG_EN, port 3 granted and in_ready never asserted -> err_timeout pulses at cycle 64 of WAIT_SOP, next grant goes to port 0.
REQ-034 Test: reset asserted on word 5 of a packet -> all outputs 0 asynchronously, no eop, port 0 granted first after release.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: port count, word geometry and the egress arbiter FSM encoding.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package switch_pkg;

  localparam int NUM_PORTS     = 4;
  localparam int WORD_W        = 32;
  localparam int MIN_PKT_WORDS = 8;
  // Word count field is the byte length [31:16] divided by four, i.e. bits [31:18].
  localparam int LEN_W         = 14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOP = 2'd1,
    STREAM   = 2'd2
  } arb_state_t;

  // Packet length in words taken from the first word, floored at MIN_PKT_WORDS.
  function automatic logic [LEN_W-1:0] pkt_words(input logic [WORD_W-1:0] sop_word);
    logic [LEN_W-1:0] w;
    w = sop_word[31:18];
    return (w < LEN_W'(MIN_PKT_WORDS)) ? LEN_W'(MIN_PKT_WORDS) : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after last_grant, wrapping around.
// Latency: purely combinational.
// Backpressure: none; valid is low when no requester is active.
// Ports: req (one bit per requester), last_grant (index), grant (one-hot), valid.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic             valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    // Offsets 1..N visit every port once, ending on last_grant itself.
    for (int k = 1; k <= N; k++) begin
      if (!valid && req[(int'(last_grant) + k) % N]) begin
        grant[(int'(last_grant) + k) % N] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/egress_arbiter.sv
// Egress arbiter: round-robin grant of whole packets from NUM_PORTS generators onto one stream.
// Latency: 1 cycle from send_en-qualified input word to registered out_* (plus one IDLE cycle per grant).
// Backpressure: out_stall drops send_en combinationally; no word moves while stalled.
// Ports: clk/reset (async, active high); req, in_ready, in_data per requester; out_stall;
//        send_en one-hot to the granted requester; out_data/out_valid/out_sop/out_eop/out_port;
//        err_timeout. Optional SOP watchdog is built when WATCHDOG_EN is defined.
module egress_arbiter
  import switch_pkg::*;
#(
  parameter  int NUM_PORTS   = switch_pkg::NUM_PORTS,
  parameter  int SOP_TIMEOUT = 64,
  localparam int PORT_W      = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        in_ready,
  input  logic [NUM_PORTS*WORD_W-1:0] in_data,
  input  logic                        out_stall,
  output logic [NUM_PORTS-1:0]        send_en,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_valid,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [PORT_W-1:0]           out_port,
  output logic                        err_timeout
);

  arb_state_t          state, state_nxt;
  logic [PORT_W-1:0]   grant, last_grant, rr_idx;
  logic [LEN_W-1:0]    remaining;
  logic [NUM_PORTS-1:0] rr_grant;
  logic                rr_valid;
  logic [WORD_W-1:0]   grant_word;
  logic                take_sop, take_word, last_word, sop_abort, wd_expire;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .valid      (rr_valid)
  );

  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rr_grant[i]) rr_idx = PORT_W'(i);
    end
  end

  assign grant_word = in_data[grant*WORD_W +: WORD_W];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rr_valid) state_nxt = WAIT_SOP;
      WAIT_SOP: begin
        if (take_sop)                    state_nxt = STREAM;
        else if (sop_abort || wd_expire) state_nxt = IDLE;
      end
      STREAM:   if (last_word) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output / transfer decode
  always_comb begin
    send_en   = '0;
    take_sop  = 1'b0;
    take_word = 1'b0;
    last_word = 1'b0;
    sop_abort = 1'b0;
    if (state != IDLE && !out_stall) send_en[grant] = 1'b1;
    case (state)
      WAIT_SOP: begin
        take_sop  = !out_stall && in_ready[grant];
        // A requester that withdraws before its first word forfeits its turn.
        sop_abort = !take_sop && !req[grant];
      end
      STREAM: begin
        take_word = !out_stall;
        last_word = !out_stall && (remaining == LEN_W'(1));
      end
      default: ;
    endcase
  end

  // Grant bookkeeping and registered output stream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= PORT_W'(NUM_PORTS - 1);
      remaining  <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_port   <= '0;
    end else begin
      if (state == IDLE && rr_valid) grant <= rr_idx;
      if (take_sop)       remaining <= pkt_words(grant_word) - LEN_W'(1);
      else if (take_word) remaining <= remaining - LEN_W'(1);
      if (last_word || sop_abort || wd_expire) last_grant <= grant;
      out_valid <= take_sop || take_word;
      out_sop   <= take_sop;
      out_eop   <= last_word;
      if (take_sop || take_word) begin
        out_data <= grant_word;
        out_port <= grant;
      end
    end
  end

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(SOP_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  // Fires on the SOP_TIMEOUT-th consecutive WAIT_SOP cycle without a first word.
  assign wd_expire = (state == WAIT_SOP) && !take_sop && (wd_cnt == WD_W'(SOP_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wd_expire;
      if (state == WAIT_SOP && !wd_expire) wd_cnt <= wd_cnt + WD_W'(1);
      else                                 wd_cnt <= '0;
    end
  end
`else
  assign wd_expire = 1'b0;
  // Constant 0; SOP_TIMEOUT is referenced so the parameter list is identical in both builds.
  assign err_timeout = 1'b0 && (SOP_TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_egress_arbiter.sv
// Self-checking bench for egress_arbiter: packet generators per port, packet-level reference model.
// Latency: n/a.
// Backpressure: random and directed out_stall, random SOP delays.
module tb_egress_arbiter;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] req, in_ready, send_en;
  logic [NP*32-1:0] in_data;
  logic          out_stall;
  logic [31:0]   out_data;
  logic          out_valid, out_sop, out_eop, err_timeout;
  logic [1:0]    out_port;

  always #5 clk = ~clk;

  egress_arbiter #(.NUM_PORTS(NP), .SOP_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req(req), .in_ready(in_ready), .in_data(in_data),
    .out_stall(out_stall), .send_en(send_en), .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port), .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Generator side (stimulus)
  int gq_bytes[NP][$];
  int gq_id[NP][$];
  bit gq_dead[NP][$];
  int cursor[NP];
  bit consumed[NP];
  int ready_pct = 100;
  int stall_pct = 0;
  int force_stall = 0;
  int next_id = 1;

  // Reference model (packet level)
  int mq_bytes[NP][$];
  int mq_id[NP][$];
  bit mq_dead[NP][$];
  int m_last = NP - 1;
  int cur_port = -1;
  int cur_id, cur_bytes, cur_len, cur_idx, gap_cnt;
  int sop_log[$];
  int len_log[$];
  int gap_log[$];
  int pkts_done = 0;
  int wd_pulses = 0;
  bit prev_err = 1'b0;

  function automatic int words_of(input int bytes);
    int w;
    w = bytes / 4;
    return (w < 8) ? 8 : w;
  endfunction

  function automatic logic [31:0] word_of(input int port, input int id, input int idx, input int bytes);
    if (idx == 0) return {bytes[15:0], id[7:0], 6'd0, port[1:0]};
    return {4'hA, port[3:0], id[7:0], idx[15:0]};
  endfunction

  // Next owner: first port after the last finished/aborted one with a packet waiting.
  function automatic int rr_pick(input int last);
    for (int k = 1; k <= NP; k++) begin
      if (mq_bytes[(last + k) % NP].size() > 0) return (last + k) % NP;
    end
    return -1;
  endfunction

  task automatic add_pkt(input int p, input int bytes, input bit dead);
    gq_bytes[p].push_back(bytes); gq_id[p].push_back(next_id); gq_dead[p].push_back(dead);
    mq_bytes[p].push_back(bytes); mq_id[p].push_back(next_id); mq_dead[p].push_back(dead);
    next_id++;
  endtask

  function automatic bit all_idle();
    for (int p = 0; p < NP; p++) if (gq_bytes[p].size() > 0) return 1'b0;
    return cur_port == -1;
  endfunction

  task automatic monitor();
`ifdef WATCHDOG_EN
    if (err_timeout) begin
      wd_pulses++;
      check("err_pulse_width", prev_err, 0);
      check("err_outside_wait", cur_port, -1);
      for (int p = 0; p < NP; p++) begin
        if (mq_bytes[p].size() > 0 && mq_dead[p][0]) begin
          void'(mq_bytes[p].pop_front()); void'(mq_id[p].pop_front()); void'(mq_dead[p].pop_front());
          m_last = p;
        end
      end
    end
    prev_err = err_timeout;
`else
    check("err_timeout_tied", err_timeout, 0);
`endif
    if (out_valid) begin
      if (out_sop) begin
        int e;
        check("sop_inside_packet", cur_port, -1);
        e = rr_pick(m_last);
        check("sop_expected", (e >= 0), 1);
        if (e >= 0) begin
          check("sop_port", out_port, e);
          cur_port  = e;
          cur_bytes = mq_bytes[e].pop_front();
          cur_id    = mq_id[e].pop_front();
          void'(mq_dead[e].pop_front());
          cur_len   = words_of(cur_bytes);
          cur_idx   = 0;
          gap_cnt   = 0;
          sop_log.push_back(e);
        end
      end else begin
        check("word_inside_packet", (cur_port >= 0), 1);
      end
      if (cur_port >= 0) begin
        check("data", out_data, word_of(cur_port, cur_id, cur_idx, cur_bytes));
        check("port", out_port, cur_port);
        check("eop", out_eop, (cur_idx == cur_len - 1));
        if (cur_idx == cur_len - 1) begin
          len_log.push_back(cur_len);
          gap_log.push_back(gap_cnt);
          pkts_done++;
          m_last   = cur_port;
          cur_port = -1;
        end else begin
          cur_idx++;
        end
      end
    end else if (cur_port >= 0) begin
      gap_cnt++;
    end
  endtask

  // Cycle engine: check outputs, advance generators, drive next inputs.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int p = 0; p < NP; p++) consumed[p] = 1'b0;
        continue;
      end
      monitor();
      for (int p = 0; p < NP; p++) begin
        if (consumed[p]) begin
          cursor[p]++;
          if (cursor[p] == words_of(gq_bytes[p][0])) begin
            void'(gq_bytes[p].pop_front()); void'(gq_id[p].pop_front()); void'(gq_dead[p].pop_front());
            cursor[p] = 0;
          end
        end
        if (err_timeout && gq_bytes[p].size() > 0 && gq_dead[p][0]) begin
          void'(gq_bytes[p].pop_front()); void'(gq_id[p].pop_front()); void'(gq_dead[p].pop_front());
          cursor[p] = 0;
        end
      end
      out_stall = (force_stall > 0) ? 1'b1 : ($urandom_range(0, 99) < stall_pct);
      if (force_stall > 0) force_stall--;
      for (int p = 0; p < NP; p++) begin
        req[p]      = gq_bytes[p].size() > 0;
        in_ready[p] = req[p] && cursor[p] == 0 && !gq_dead[p][0] && ($urandom_range(0, 99) < ready_pct);
        in_data[p*32 +: 32] = req[p] ? word_of(p, gq_id[p][0], cursor[p], gq_bytes[p][0]) : $urandom;
      end
      #1;
      if (out_stall) check("send_en_stalled", send_en, 0);
      else           check("send_en_onehot", ($countones(send_en) <= 1), 1);
      for (int p = 0; p < NP; p++)
        consumed[p] = send_en[p] && req[p] && (cursor[p] > 0 || in_ready[p]);
    end
  end

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (!all_idle() && c < budget) begin
      @(negedge clk); #3; c++;
    end
    check("drain_in_budget", (c < budget), 1);
  endtask

  task automatic wait_word(input int port, input int idx, input int budget);
    int c;
    c = 0;
    while (!(cur_port == port && cur_idx == idx) && c < budget) begin
      @(negedge clk); #3; c++;
    end
    check("reach_word", (c < budget), 1);
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) begin
      gq_bytes[p].delete(); gq_id[p].delete(); gq_dead[p].delete();
      mq_bytes[p].delete(); mq_id[p].delete(); mq_dead[p].delete();
      cursor[p] = 0; consumed[p] = 1'b0;
    end
    cur_port = -1; m_last = NP - 1; prev_err = 1'b0;
    req = '0; in_ready = '0; out_stall = 1'b0; force_stall = 0;
  endtask

  initial begin
    int exp_a[5];
    int exp_d[4];
    int base, done0, cnt;
    reset = 1'b1; req = '0; in_ready = '0; in_data = '0; out_stall = 1'b0;
    clear_all();
    repeat (3) @(negedge clk);
    #3;
    check("rst_valid", out_valid, 0); check("rst_data", out_data, 0);
    check("rst_sop", out_sop, 0);     check("rst_eop", out_eop, 0);
    check("rst_port", out_port, 0);   check("rst_send_en", send_en, 0);
    check("rst_err", err_timeout, 0);
    reset = 1'b0;
    @(negedge clk); #3;

    // Four 64-byte packets plus a second on port 0: grants 0,1,2,3,0, 16 words each.
    exp_a = '{0, 1, 2, 3, 0};
    sop_log.delete(); len_log.delete();
    for (int i = 0; i < 5; i++) add_pkt(exp_a[i], 64, 1'b0);
    drain(600);
    check("a_count", sop_log.size(), 5);
    for (int i = 0; i < 5 && i < sop_log.size(); i++) begin
      check("a_order", sop_log[i], exp_a[i]);
      check("a_len", len_log[i], 16);
    end

    // Short packet forced to minimum length.
    sop_log.delete(); len_log.delete();
    add_pkt(2, 16'h0010, 1'b0);
    drain(100);
    check("b_port", (sop_log.size() > 0) ? sop_log[0] : -1, 2);
    check("b_len", (len_log.size() > 0) ? len_log[0] : -1, 8);

    // Three stall cycles mid-packet.
    len_log.delete(); gap_log.delete();
    add_pkt(0, 64, 1'b0);
    wait_word(0, 6, 50);
    force_stall = 3;
    drain(100);
    check("c_len", (len_log.size() > 0) ? len_log[0] : -1, 16);
    check("c_gaps", (gap_log.size() > 0) ? gap_log[0] : -1, 3);

    // Long packet on port 1; other ports request mid-stream and must wait.
    exp_d = '{1, 2, 3, 0};
    sop_log.delete(); len_log.delete();
    add_pkt(1, 2048, 1'b0);
    wait_word(1, 50, 100);
    add_pkt(0, 64, 1'b0); add_pkt(2, 64, 1'b0); add_pkt(3, 64, 1'b0);
    drain(2000);
    check("d_count", sop_log.size(), 4);
    check("d_len", (len_log.size() > 0) ? len_log[0] : -1, 512);
    for (int i = 0; i < 4 && i < sop_log.size(); i++) check("d_order", sop_log[i], exp_d[i]);

    // Randomized traffic with backpressure and late SOPs.
    stall_pct = 25; ready_pct = 60;
    for (int r = 0; r < 3; r++) begin
      done0 = pkts_done;
      for (int i = 0; i < 6; i++) add_pkt($urandom_range(0, NP-1), $urandom_range(0, 200), 1'b0);
      drain(3000);
      check("rand_pkts", pkts_done - done0, 6);
    end
    stall_pct = 0; ready_pct = 100;

`ifdef WATCHDOG_EN
    // Port 3 never presents its first word; watchdog aborts after 64 WAIT_SOP cycles.
    sop_log.delete();
    wd_pulses = 0;
    add_pkt(3, 64, 1'b1);
    cnt = 0;
    while (!send_en[3] && cnt < 20) begin @(negedge clk); #3; cnt++; end
    check("wd_granted", send_en[3], 1);
    add_pkt(0, 64, 1'b0);
    cnt = 1;
    base = 0;
    while (!err_timeout && base < 200) begin
      @(negedge clk); #3; base++;
      if (!err_timeout && send_en[3]) cnt++;
    end
    check("wd_fired", err_timeout, 1);
    check("wd_cycles", cnt, 64);
    drain(200);
    check("wd_pulses", wd_pulses, 1);
    check("wd_next_port", (sop_log.size() > 0) ? sop_log[0] : -1, 0);
`endif

    // Reset on word 5 of a packet: outputs clear at once, packet dropped, port 0 first after.
    add_pkt(1, 64, 1'b0);
    wait_word(1, 5, 50);
    done0 = pkts_done;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0); check("mid_rst_data", out_data, 0);
    check("mid_rst_sop", out_sop, 0);     check("mid_rst_eop", out_eop, 0);
    check("mid_rst_port", out_port, 0);   check("mid_rst_send_en", send_en, 0);
    check("mid_rst_err", err_timeout, 0);
    clear_all();
    check("mid_rst_no_eop", pkts_done, done0);
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b0;
    sop_log.delete();
    add_pkt(2, 64, 1'b0);
    add_pkt(0, 64, 1'b0);
    drain(200);
    check("post_rst_first", (sop_log.size() > 0) ? sop_log[0] : -1, 0);
    check("post_rst_second", (sop_log.size() > 1) ? sop_log[1] : -1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
